apb_master: RTL and testbench

Single-outstanding APB requester that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers. It sits directly upstream of `apb_ram`, driving that slave's `psel`/`penable`/`pwrite`/`paddr`/`pwdata` and consuming `prdata`/`pready`/`pslverr`. It returns one response per command. It replaces the testbench driver when the slave is exercised from RTL (e.g. by a bus bridge or a self-test sequencer).

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_wdog.sv | 38 +++
 rtl/apb_master.sv | 156 +++++++++++++++
 tb/tb_apb_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths
// and the command payload struct.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_wdog.sv
// Saturating ACCESS wait counter; expired flags when the count reaches TIMEOUT_CYCLES.
// Instantiated by apb_master only when APB_MASTER_TIMEOUT_EN is defined.
module apb_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding valid/ready command to APB SETUP/ACCESS requester.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_master_state_e state_q;
    apb_master_state_e state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              timeout_c;

`ifdef APB_MASTER_TIMEOUT_EN
    logic wdog_expired;

    apb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (pclk),
        .rst    (preset),
        .clr    (state_q == SETUP),
        .inc    ((state_q == ACCESS) && !pready),
        .expired(wdog_expired)
    );

    // A pready arriving in the expiry cycle still completes normally.
    assign timeout_c = (state_q == ACCESS) && !pready && wdog_expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_c          = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || timeout_c) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs follow the upcoming state so they leave the flops aligned with it.
    always_comb begin
        psel_d        = (state_d == SETUP) || (state_d == ACCESS);
        penable_d     = (state_d == ACCESS);
        cmd_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == RESP);
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        if ((state_q == IDLE) && cmd_valid) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
        end

        if (state_q == ACCESS) begin
            if (pready) begin
                rsp_rdata_d   = pwrite_q ? '0 : prdata;
                rsp_err_d     = pslverr;
                rsp_timeout_d = 1'b0;
            end else if (timeout_c) begin
                rsp_rdata_d   = '0;
                rsp_err_d     = 1'b1;
                rsp_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a transaction-timeline model plus an in-bench APB RAM slave,
// compared against the DUT every cycle, with directed literal checks and random traffic.
module tb_apb_master;
    import apb_pkg::*;

    localparam int unsigned TO = 4;

    logic        pclk      = 1'b0;
    logic        preset    = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata    = '0;
    logic        pready    = 1'b0;
    logic        pslverr   = 1'b0;

    apb_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus plan for the next cycle
    bit       d_preset    = 1'b1;
    bit       d_cmd_valid = 1'b0;
    apb_cmd_t d_cmd       = '0;
    bit       d_rsp_ready = 1'b1;
    int       d_w         = 0;
    bit       d_err       = 1'b0;

    // transaction-level model: age = cycles since the accept cycle
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_w    = 0;
    bit          m_err  = 1'b0;
    apb_cmd_t    m_cmd  = '0;
    logic [31:0] e_paddr = '0, e_pwdata = '0, e_rdata = '0;
    logic        e_pwrite = 1'b0, e_err = 1'b0, e_to = 1'b0;
    logic [31:0] mem [16];

    logic        drv_pready = 1'b0, drv_pslverr = 1'b0;
    logic [31:0] drv_prdata = '0;

    logic        s_cmd_ready, s_rsp_valid, s_psel, s_rsp_err, s_rsp_timeout;
    logic [31:0] s_rsp_rdata;

    function automatic bit m_timed();
`ifdef APB_MASTER_TIMEOUT_EN
        return (m_w > int'(TO));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int weff();
        return m_timed() ? int'(TO) : m_w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        int we;
        @(posedge pclk);
        #1;
        preset    = d_preset;
        cmd_valid = d_cmd_valid;
        cmd_write = d_cmd.write;
        cmd_addr  = d_cmd.addr;
        cmd_wdata = d_cmd.wdata;
        rsp_ready = d_rsp_ready;
        if (m_busy && m_age >= 2 && m_age <= 2 + m_w) begin
            drv_pready  = (m_age == 2 + m_w);
            drv_pslverr = drv_pready ? m_err : 1'($urandom());
            drv_prdata  = drv_pready ? mem[m_cmd.addr[5:2]] : $urandom();
        end else begin
            drv_pready  = 1'($urandom());
            drv_pslverr = 1'($urandom());
            drv_prdata  = $urandom();
        end
        pready  = drv_pready;
        pslverr = drv_pslverr;
        prdata  = drv_prdata;

        @(negedge pclk);
        s_cmd_ready   = cmd_ready;
        s_rsp_valid   = rsp_valid;
        s_psel        = psel;
        s_rsp_rdata   = rsp_rdata;
        s_rsp_err     = rsp_err;
        s_rsp_timeout = rsp_timeout;

        we = weff();
        chk("cmd_ready",   32'(cmd_ready),   32'(!m_busy));
        chk("psel",        32'(psel),        32'(m_busy && m_age >= 1 && m_age <= 2 + we));
        chk("penable",     32'(penable),     32'(m_busy && m_age >= 2 && m_age <= 2 + we));
        chk("rsp_valid",   32'(rsp_valid),   32'(m_busy && m_age >= 3 + we));
        chk("pwrite",      32'(pwrite),      32'(e_pwrite));
        chk("paddr",       paddr,            e_paddr);
        chk("pwdata",      pwdata,           e_pwdata);
        chk("rsp_rdata",   rsp_rdata,        e_rdata);
        chk("rsp_err",     32'(rsp_err),     32'(e_err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));

        // advance the model across the coming edge
        if (d_preset) begin
            m_busy   = 1'b0;
            m_age    = 0;
            e_paddr  = '0;
            e_pwdata = '0;
            e_pwrite = 1'b0;
            e_rdata  = '0;
            e_err    = 1'b0;
            e_to     = 1'b0;
        end else if (!m_busy) begin
            if (d_cmd_valid) begin
                m_busy   = 1'b1;
                m_age    = 1;
                m_cmd    = d_cmd;
                m_w      = d_w;
                m_err    = d_err;
                e_paddr  = d_cmd.addr;
                e_pwrite = d_cmd.write;
                e_pwdata = d_cmd.write ? d_cmd.wdata : 32'h0;
            end
        end else begin
            if (m_age == 2 + we) begin
                if (m_timed()) begin
                    e_rdata = '0;
                    e_err   = 1'b1;
                    e_to    = 1'b1;
                end else begin
                    e_rdata = m_cmd.write ? 32'h0 : drv_prdata;
                    e_err   = drv_pslverr;
                    e_to    = 1'b0;
                    if (m_cmd.write && !drv_pslverr) mem[m_cmd.addr[5:2]] = m_cmd.wdata;
                end
            end
            if (m_age >= 3 + we && d_rsp_ready) m_busy = 1'b0;
            m_age++;
        end
    endtask

    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int w, input bit err, input int hold,
                          output int lat_rsp, output int lat_rdy,
                          output logic [31:0] rd, output logic er, output logic to);
        int n;
        int seen;
        lat_rsp = -1;
        lat_rdy = -1;
        rd      = '0;
        er      = 1'b0;
        to      = 1'b0;
        seen    = 0;
        d_cmd.write = wr;
        d_cmd.addr  = a;
        d_cmd.wdata = wd;
        d_w         = w;
        d_err       = err;
        d_cmd_valid = 1'b1;
        d_rsp_ready = (hold == 0);
        cycle();
        d_cmd_valid = 1'b0;
        n = 0;
        while (lat_rdy < 0 && n < 200) begin
            cycle();
            n++;
            if (s_rsp_valid) begin
                if (lat_rsp < 0) begin
                    lat_rsp = n;
                    rd      = s_rsp_rdata;
                    er      = s_rsp_err;
                    to      = s_rsp_timeout;
                end
                seen++;
            end
            if (s_cmd_ready) lat_rdy = n;
            d_rsp_ready = (seen >= hold);
            // offer a competing command while the response is stalled
            d_cmd_valid = (seen > 0 && seen < hold);
            if (d_cmd_valid) begin
                d_cmd.write = 1'($urandom());
                d_cmd.addr  = $urandom();
                d_cmd.wdata = $urandom();
            end
        end
        d_cmd_valid = 1'b0;
        d_rsp_ready = 1'b1;
        if (lat_rdy < 0) chk("txn_completes", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lr, ly, rsp_seen;
        logic [31:0] rd;
        logic        er, to;

        for (int i = 0; i < 16; i++) mem[i] = '0;

        cycle();
        cycle();
        chk("reset_cmd_ready", 32'(s_cmd_ready), 32'd1);
        chk("reset_psel",      32'(s_psel),      32'd0);
        chk("reset_rsp_valid", 32'(s_rsp_valid), 32'd0);
        d_preset = 1'b0;
        cycle();

        do_txn(1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 0, lr, ly, rd, er, to);
        chk("wr_lat_rsp", 32'(lr), 32'd3);
        chk("wr_lat_rdy", 32'(ly), 32'd4);
        chk("wr_err",     32'(er), 32'd0);

        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, lr, ly, rd, er, to);
        chk("rd_data",    rd,      32'hA5A5_0001);
        chk("rd_err",     32'(er), 32'd0);
        chk("rd_lat_rdy", 32'(ly), 32'd4);

        do_txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 0, lr, ly, rd, er, to);
        chk("wait3_lat_rsp", 32'(lr), 32'd6);
        chk("wait3_data",    rd,      32'hA5A5_0001);

        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b1, 0, lr, ly, rd, er, to);
        chk("slverr_err",   32'(er), 32'd1);
        chk("slverr_to",    32'(to), 32'd0);
        chk("slverr_rdata", rd,      32'd0);

        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 5, lr, ly, rd, er, to);
        chk("stall_lat_rsp", 32'(lr), 32'd3);
        chk("stall_lat_rdy", 32'(ly), 32'd9);
        chk("stall_data",    rd,      32'hA5A5_0001);

        // reset during ACCESS drops the transfer
        d_cmd.write = 1'b0;
        d_cmd.addr  = 32'h10;
        d_cmd.wdata = '0;
        d_w         = 5;
        d_err       = 1'b0;
        d_cmd_valid = 1'b1;
        cycle();
        d_cmd_valid = 1'b0;
        cycle();
        cycle();
        d_preset = 1'b1;
        cycle();
        d_preset = 1'b0;
        cycle();
        chk("midrst_cmd_ready", 32'(s_cmd_ready), 32'd1);
        chk("midrst_psel",      32'(s_psel),      32'd0);
        rsp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_rsp_valid) rsp_seen++;
        end
        chk("midrst_no_rsp", 32'(rsp_seen), 32'd0);
        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, lr, ly, rd, er, to);
        chk("midrst_after_data", rd, 32'hA5A5_0001);

        do_txn(1'b0, 32'h10, 32'h0, 10, 1'b0, 0, lr, ly, rd, er, to);
`ifdef APB_MASTER_TIMEOUT_EN
        chk("tmo_err",     32'(er), 32'd1);
        chk("tmo_flag",    32'(to), 32'd1);
        chk("tmo_lat_rsp", 32'(lr), 32'd7);
`else
        chk("long_wait_to",      32'(to), 32'd0);
        chk("long_wait_lat_rsp", 32'(lr), 32'd13);
        chk("long_wait_data",    rd,      32'hA5A5_0001);
`endif

        for (int t = 0; t < 200; t++) begin
            int gap;
            int w;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cycle();
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            do_txn(1'($urandom()), $urandom(), $urandom(), w, ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 3)), lr, ly, rd, er, to);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
